id_ex_hazard_stage: RTL and testbench

//  ID->EX boundary of the 5-stage RV32I pipeline; consumes decoder control bits and operands.

---
 rtl/id_ex_hazard_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID->EX boundary of the 5-stage RV32I pipeline.
// Detects load-use / RAW hazards, stalls IF/ID, injects bubbles into ID/EX,
// and sequences the ECALL (x17==10) halt: drain EX/MEM/WB, then raise is_halted.
// Optional build macro: FORWARDING_EN -- when defined, only load-use stalls;
// when undefined, any pending writer in EX/MEM/WB of a read source stalls.
module id_ex_hazard_stage #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_mem_read,
    input  logic            id_mem_to_reg,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_write_enable,
    input  logic            id_is_ecall,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_x17_data,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            mem_we,
    input  logic            wb_we,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_write_enable,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic            is_halted
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // ECALL implicitly reads x17 through the rs1 port for hazard purposes.
    logic [4:0] src1;
    logic       use1;
    logic       hazard_ld, hazard_x17, hazard_raw, hazard;
    logic       halt_req, load_id;

    assign src1 = id_is_ecall ? 5'd17 : id_rs1;
    assign use1 = id_is_ecall | id_uses_rs1;

    // A read source collides with a live writer of the same non-zero register.
    function automatic logic hit(input logic used, input logic [4:0] src,
                                 input logic wr, input logic [4:0] rd);
        return used & wr & (rd != 5'd0) & (src == rd);
    endfunction

    // Hazard detection: load-use always, x17 producer for ECALL, and the
    // full RAW scoreboard only when values are not forwarded.
    always_comb begin
        hazard_ld  = id_valid & ex_valid & ex_mem_read &
                     (hit(use1, src1, 1'b1, ex_rd) | hit(id_uses_rs2, id_rs2, 1'b1, ex_rd));
        hazard_x17 = id_valid & id_is_ecall & ex_valid & ex_write_enable & (ex_rd == 5'd17);
`ifdef FORWARDING_EN
        hazard_raw = 1'b0;
`else
        hazard_raw = id_valid &
                     (hit(use1, src1, ex_valid & ex_write_enable, ex_rd) |
                      hit(id_uses_rs2, id_rs2, ex_valid & ex_write_enable, ex_rd) |
                      hit(use1, src1, mem_we, mem_rd) |
                      hit(id_uses_rs2, id_rs2, mem_we, mem_rd) |
                      hit(use1, src1, wb_we, wb_rd) |
                      hit(id_uses_rs2, id_rs2, wb_we, wb_rd));
`endif
        hazard = hazard_ld | hazard_x17 | hazard_raw;
    end

    // ECALL only commits when it actually leaves ID this cycle.
    assign halt_req = id_valid & id_is_ecall & ~stall & (id_x17_data == XLEN'(10));
    // ECALL itself never enters EX; it becomes a bubble.
    assign load_id  = id_valid & ~stall & ~id_is_ecall;

    // Halt FSM state and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Halt FSM next state: RUN -> DRAIN on a committed halting ECALL, count down, then stick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: if (halt_req) begin
                state_nxt = DRAIN;
                cnt_nxt   = CW'(DRAIN_CYCLES - 1);
            end
            DRAIN: if (cnt == '0) state_nxt = HALTED;
                   else           cnt_nxt   = cnt - 1'b1;
            HALTED: state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Halt FSM outputs: any non-RUN state freezes the front end.
    always_comb begin
        stall     = hazard | (state != RUN);
        is_halted = (state == HALTED);
    end

    // ID/EX register: take the ID instruction or insert a bubble (data held).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid        <= 1'b0;
            ex_mem_read     <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_alu_src      <= 1'b0;
            ex_write_enable <= 1'b0;
            ex_rs1          <= '0;
            ex_rs2          <= '0;
            ex_rd           <= '0;
            ex_rs1_data     <= '0;
            ex_rs2_data     <= '0;
            ex_imm          <= '0;
            ex_pc           <= '0;
        end else if (load_id) begin
            ex_valid        <= 1'b1;
            ex_mem_read     <= id_mem_read;
            ex_mem_to_reg   <= id_mem_to_reg;
            ex_mem_write    <= id_mem_write;
            ex_alu_src      <= id_alu_src;
            ex_write_enable <= id_write_enable;
            ex_rs1          <= id_rs1;
            ex_rs2          <= id_rs2;
            ex_rd           <= id_rd;
            ex_rs1_data     <= id_rs1_data;
            ex_rs2_data     <= id_rs2_data;
            ex_imm          <= id_imm;
            ex_pc           <= id_pc;
        end else begin
            ex_valid        <= 1'b0;
            ex_mem_read     <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_alu_src      <= 1'b0;
            ex_write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed literal cases plus randomized traffic
// compared every cycle against a behavioural pipeline model.
module tb_id_ex_hazard_stage;

    localparam int DRAIN = 3;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, reset;
    logic        id_valid, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src;
    logic        id_write_enable, id_is_ecall, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, id_x17_data;
    logic        mem_we, wb_we;
    logic        stall, ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic        ex_write_enable, is_halted;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;

    id_ex_hazard_stage #(.XLEN(32), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_write_enable(id_write_enable), .id_is_ecall(id_is_ecall),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_x17_data(id_x17_data), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we), .stall(stall), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_write_enable(ex_write_enable), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .is_halted(is_halted)
    );

    typedef struct packed {
        logic        valid, mem_read, mem_to_reg, mem_write, alu_src, we;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data, imm, pc;
    } ex_t;

    ex_t dut_ex;
    assign dut_ex = {ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                     ex_write_enable, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
                     ex_imm, ex_pc};

    int tests = 0;
    int fails = 0;
    bit cmp_on = 1'b0;

    // Model state: ID/EX contents, edges left in the drain, halted flag.
    ex_t m;
    int  m_left;
    bit  m_halted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the instruction in ID have to wait this cycle?
    function automatic bit model_stall();
        logic [4:0] src[2];
        bit         use_[2];
        if (m_halted || m_left > 0) return 1'b1;
        if (!id_valid) return 1'b0;
        src[0]  = id_is_ecall ? 5'd17 : id_rs1;
        use_[0] = id_is_ecall || id_uses_rs1;
        src[1]  = id_rs2;
        use_[1] = id_uses_rs2;
        for (int k = 0; k < 2; k++) begin
            if (use_[k] && src[k] != 5'd0) begin
                if (m.valid && m.mem_read && m.rd == src[k]) return 1'b1;
                if (!FWD) begin
                    if (m.valid && m.we && m.rd == src[k]) return 1'b1;
                    if (mem_we && mem_rd == src[k]) return 1'b1;
                    if (wb_we && wb_rd == src[k]) return 1'b1;
                end
            end
        end
        if (id_is_ecall && m.valid && m.we && m.rd == 5'd17) return 1'b1;
        return 1'b0;
    endfunction

    // Model advance on each clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m        <= '0;
            m_left   <= 0;
            m_halted <= 1'b0;
        end else begin
            if (!m_halted) begin
                if (m_left > 0) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_halted <= 1'b1;
                end else if (id_valid && id_is_ecall && !model_stall() && id_x17_data == 32'd10)
                    m_left <= DRAIN;
            end
            if (id_valid && !model_stall() && !id_is_ecall) begin
                m.valid      <= 1'b1;
                m.mem_read   <= id_mem_read;
                m.mem_to_reg <= id_mem_to_reg;
                m.mem_write  <= id_mem_write;
                m.alu_src    <= id_alu_src;
                m.we         <= id_write_enable;
                m.rs1        <= id_rs1;
                m.rs2        <= id_rs2;
                m.rd         <= id_rd;
                m.rs1_data   <= id_rs1_data;
                m.rs2_data   <= id_rs2_data;
                m.imm        <= id_imm;
                m.pc         <= id_pc;
            end else begin
                m.valid      <= 1'b0;
                m.mem_read   <= 1'b0;
                m.mem_to_reg <= 1'b0;
                m.mem_write  <= 1'b0;
                m.alu_src    <= 1'b0;
                m.we         <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on && !reset) begin
            chk("model_stall", 160'(stall), 160'(model_stall()));
            chk("model_ex", 160'(dut_ex), 160'(m));
            chk("model_halted", 160'(is_halted), 160'(m_halted));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0;
        id_write_enable = 0; id_is_ecall = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_pc = 0; id_x17_data = 0; mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0;
    endtask

    task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit u1, input bit u2);
        idle();
        id_valid = 1; id_write_enable = 1; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    endtask

    task automatic ecall(input logic [31:0] x17);
        idle();
        id_valid = 1; id_is_ecall = 1; id_x17_data = x17; id_pc = 32'h100;
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        reset = 0;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 3) == 0) return 5'd17;
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cmp_on = 1'b1;
        #1;
        chk("reset_stall", 160'(stall), 160'(0));
        chk("reset_ex_valid", 160'(ex_valid), 160'(0));
        chk("reset_halted", 160'(is_halted), 160'(0));
        chk("reset_ex_pc", 160'(ex_pc), 160'(0));
        cycle();

        // lw x5 then add uses x5: one bubble, then add proceeds.
        alu(5'd2, 5'd0, 5'd5, 1, 0);
        id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1;
        cycle();
        alu(5'd5, 5'd3, 5'd7, 1, 1);
        #1 chk("lu_stall", 160'(stall), 160'(1));
        cycle();
        chk("lu_bubble", 160'(ex_valid), 160'(0));
        #1 chk("lu_release", 160'(stall), 160'(0));
        cycle();
        chk("lu_add_valid", 160'(ex_valid), 160'(1));
        chk("lu_add_rs1", 160'(ex_rs1), 160'(5));
        chk("lu_add_rd", 160'(ex_rd), 160'(7));

        // Load to x0 then use x0: never a hazard.
        alu(5'd1, 5'd0, 5'd0, 1, 0);
        id_mem_read = 1;
        cycle();
        alu(5'd0, 5'd0, 5'd9, 1, 0);
        #1 chk("x0_no_stall", 160'(stall), 160'(0));
        cycle();
        chk("x0_valid", 160'(ex_valid), 160'(1));

        // Producer of x6 in MEM then WB, consumer reads x6.
        idle();
        cycle();
        alu(5'd6, 5'd0, 5'd8, 1, 0);
        mem_we = 1; mem_rd = 5'd6;
        #1 chk("mem_raw_stall", 160'(stall), 160'(FWD ? 0 : 1));
        cycle();
        mem_we = 0; wb_we = 1; wb_rd = 5'd6;
        #1 chk("wb_raw_stall", 160'(stall), 160'(FWD ? 0 : 1));
        cycle();
        wb_we = 0;
        #1 chk("raw_clear", 160'(stall), 160'(0));
        cycle();
        chk("raw_sub_rs1", 160'(ex_rs1), 160'(6));
        chk("raw_sub_valid", 160'(ex_valid), 160'(1));

        // ECALL with x17 != 10: bubble, no halt.
        ecall(32'd9);
        #1 chk("ecall9_stall", 160'(stall), 160'(0));
        cycle();
        chk("ecall9_bubble", 160'(ex_valid), 160'(0));
        chk("ecall9_halted", 160'(is_halted), 160'(0));
        idle();
        cycle();

        // ECALL with x17 == 10: halted exactly DRAIN+1 edges later.
        ecall(32'd10);
        cycle();
        alu(5'd1, 5'd2, 5'd3, 1, 1);
        for (int i = 1; i <= DRAIN; i++) begin
            chk("drain_halted", 160'(is_halted), 160'(0));
            chk("drain_stall", 160'(stall), 160'(1));
            cycle();
        end
        chk("halt_set", 160'(is_halted), 160'(1));
        chk("halt_stall", 160'(stall), 160'(1));
        chk("halt_bubble", 160'(ex_valid), 160'(0));

        // Async reset in the middle of a drain.
        do_reset();
        ecall(32'd10);
        cycle();
        idle();
        cycle();
        reset = 1;
        #1;
        chk("rst_drain_halted", 160'(is_halted), 160'(0));
        chk("rst_drain_stall", 160'(stall), 160'(0));
        chk("rst_drain_valid", 160'(ex_valid), 160'(0));
        reset = 0;
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ((m_halted && $urandom_range(0, 7) == 0) || (m_left > 0 && $urandom_range(0, 29) == 0))
                do_reset();
            id_valid        = ($urandom_range(0, 7) != 0);
            id_mem_read     = ($urandom_range(0, 3) == 0);
            id_mem_to_reg   = id_mem_read;
            id_mem_write    = ($urandom_range(0, 5) == 0);
            id_alu_src      = 1'($urandom);
            id_write_enable = ($urandom_range(0, 3) != 0);
            id_is_ecall     = ($urandom_range(0, 19) == 0);
            id_uses_rs1     = 1'($urandom);
            id_uses_rs2     = 1'($urandom);
            id_rs1          = rreg();
            id_rs2          = rreg();
            id_rd           = rreg();
            id_rs1_data     = $urandom;
            id_rs2_data     = $urandom;
            id_imm          = $urandom;
            id_pc           = $urandom;
            id_x17_data     = $urandom_range(0, 1) ? 32'd10 : 32'($urandom_range(0, 20));
            mem_we          = ($urandom_range(0, 3) == 0);
            mem_rd          = rreg();
            wb_we           = ($urandom_range(0, 3) == 0);
            wb_rd           = rreg();
            cycle();
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
